// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, DELAY-stage sync/blank pipeline.
// The optional frame counter is built only when VTG_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   XY_W     = 10,
  parameter int   DELAY    = 1,
  parameter int   FRAME_W  = 16
) (
  input  logic               pixel_clk,
  input  logic               reset,
  output logic [XY_W-1:0]    drawX,
  output logic [XY_W-1:0]    drawY,
  output logic               hs,
  output logic               vs,
  output logic               active_nblank,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DEPTH = DELAY;

  localparam logic [XY_W-1:0] H_LAST   = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0] V_LAST   = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0] HS_START = XY_W'(H_ACTIVE + H_FP);
  localparam logic [XY_W-1:0] HS_END   = XY_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XY_W-1:0] VS_START = XY_W'(V_ACTIVE + V_FP);
  localparam logic [XY_W-1:0] VS_END   = XY_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XY_W-1:0] H_VIS    = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0] V_VIS    = XY_W'(V_ACTIVE);

  if (DELAY < 1 || DELAY > 8) begin : g_bad_delay
    $error("vga_timing_gen: DELAY must be in 1..8");
  end
  if ((H_TOTAL - 1) >= (1 << XY_W) || (V_TOTAL - 1) >= (1 << XY_W)) begin : g_bad_xy_w
    $error("vga_timing_gen: XY_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [XY_W-1:0] hc;
  logic [XY_W-1:0] vc;
  logic            h_wrap;
  logic            v_wrap;
  logic [2:0]      dec;
  logic [2:0]      pipe [DEPTH];

  always_comb begin
    h_wrap = (hc == H_LAST);
    v_wrap = (vc == V_LAST);
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (h_wrap) begin
      hc <= '0;
      vc <= v_wrap ? '0 : vc + XY_W'(1);
    end else begin
      hc <= hc + XY_W'(1);
    end
  end

  // dec = {hs_d, vs_d, de_d}; pipeline stores true-when-active, polarity applied at the output
  always_comb begin
    dec    = '0;
    dec[2] = (hc >= HS_START) && (hc < HS_END);
    dec[1] = (vc >= VS_START) && (vc < VS_END);
    dec[0] = (hc < H_VIS) && (vc < V_VIS);
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= dec;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign drawX         = hc;
  assign drawY         = vc;
  assign hs            = ~(pipe[DEPTH-1][2] ^ HS_POL);
  assign vs            = ~(pipe[DEPTH-1][1] ^ VS_POL);
  assign active_nblank = pipe[DEPTH-1][0];
  assign sof           = (hc == '0) && (vc == '0);
  assign eol           = h_wrap;

`ifdef VTG_FRAME_CNT_EN
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset)                frame_cnt <= '0;
    else if (h_wrap && v_wrap) frame_cnt <= frame_cnt + FRAME_W'(1);
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default, DELAY=4, inverted polarity and a
// small raster used for frame-level behaviour (strobes, vs width, frame_cnt, mid-frame reset).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_s = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_a;
  int n_s;

  // Edges since reset release, one per reset domain
  always @(posedge clk or posedge rst_a) if (rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or posedge rst_s) if (rst_s) n_s <= 0; else n_s <= n_s + 1;

  logic [9:0]  def_x, def_y, d4_x, d4_y, pol_x, pol_y, sm_x, sm_y;
  logic        def_hs, def_vs, def_de, def_sof, def_eol;
  logic        d4_hs, d4_vs, d4_de, d4_sof, d4_eol;
  logic        pol_hs, pol_vs, pol_de, pol_sof, pol_eol;
  logic        sm_hs, sm_vs, sm_de, sm_sof, sm_eol;
  logic [15:0] def_fc, d4_fc, pol_fc;
  logic [1:0]  sm_fc;

  vga_timing_gen #(.DELAY(1)) u_def (
    .pixel_clk(clk), .reset(rst_a), .drawX(def_x), .drawY(def_y), .hs(def_hs), .vs(def_vs),
    .active_nblank(def_de), .sof(def_sof), .eol(def_eol), .frame_cnt(def_fc));

  vga_timing_gen #(.DELAY(4)) u_d4 (
    .pixel_clk(clk), .reset(rst_a), .drawX(d4_x), .drawY(d4_y), .hs(d4_hs), .vs(d4_vs),
    .active_nblank(d4_de), .sof(d4_sof), .eol(d4_eol), .frame_cnt(d4_fc));

  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1), .DELAY(1)) u_pol (
    .pixel_clk(clk), .reset(rst_a), .drawX(pol_x), .drawY(pol_y), .hs(pol_hs), .vs(pol_vs),
    .active_nblank(pol_de), .sof(pol_sof), .eol(pol_eol), .frame_cnt(pol_fc));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .DELAY(1), .FRAME_W(2)) u_small (
    .pixel_clk(clk), .reset(rst_s), .drawX(sm_x), .drawY(sm_y), .hs(sm_hs), .vs(sm_vs),
    .active_nblank(sm_de), .sof(sm_sof), .eol(sm_eol), .frame_cnt(sm_fc));

  // Expected decoded terms at edge n for a generator released at edge 0
  function automatic void exp_dec(input int n, input int d, input int ht, input int vt,
                                  input int hss, input int hsl, input int vss, input int vsl,
                                  input int ha, input int va,
                                  output bit hsd, output bit vsd, output bit de);
    int m, h, v;
    hsd = 1'b0; vsd = 1'b0; de = 1'b0;
    if (n >= d) begin
      m   = n - d;
      h   = m % ht;
      v   = (m / ht) % vt;
      hsd = (h >= hss) && (h < hss + hsl);
      vsd = (v >= vss) && (v < vss + vsl);
      de  = (h < ha) && (v < va);
    end
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (def_x !== 10'd0 || def_y !== 10'd0) begin errors++;
      $display("FAIL reset_xy got %0d,%0d exp 0,0", def_x, def_y); end
    checks++; if (def_hs !== 1'b1 || def_vs !== 1'b1) begin errors++;
      $display("FAIL reset_sync got hs=%b vs=%b exp 1,1", def_hs, def_vs); end
    checks++; if (def_de !== 1'b0 || d4_de !== 1'b0) begin errors++;
      $display("FAIL reset_blank got %b,%b exp 0,0", def_de, d4_de); end
    checks++; if (def_sof !== 1'b1 || def_eol !== 1'b0) begin errors++;
      $display("FAIL reset_strobes got sof=%b eol=%b exp 1,0", def_sof, def_eol); end
    checks++; if (def_fc !== 16'd0 || sm_fc !== 2'd0) begin errors++;
      $display("FAIL reset_frame_cnt got %0d,%0d exp 0,0", def_fc, sm_fc); end
    checks++; if (pol_hs !== 1'b0 || pol_vs !== 1'b0) begin errors++;
      $display("FAIL reset_pol_sync got hs=%b vs=%b exp 0,0", pol_hs, pol_vs); end
    checks++; if (d4_hs !== 1'b1 || d4_vs !== 1'b1) begin errors++;
      $display("FAIL reset_d4_sync got hs=%b vs=%b exp 1,1", d4_hs, d4_vs); end
  endtask

  task automatic test_default_lines();
    bit   hsd, vsd, de, hsd4, vsd4, de4;
    int   n;
    int   first_hs = -1, hs_run = 0, run_done = 0;
    int   de4_rise = -1, de4_fall = -1, eol0 = -1, eol1 = -1;
    logic prev_de4 = 1'b0;
    @(negedge clk); rst_a = 1'b0;
    for (int k = 0; k < 1700; k++) begin
      @(posedge clk); #1;
      n = n_a;
      exp_dec(n, 1, 800, 525, 656, 96, 490, 2, 640, 480, hsd, vsd, de);
      exp_dec(n, 4, 800, 525, 656, 96, 490, 2, 640, 480, hsd4, vsd4, de4);
      checks++; if (def_x !== 10'(n % 800) || def_y !== 10'(n / 800)) begin errors++;
        $display("FAIL def_xy n=%0d got %0d,%0d exp %0d,%0d", n, def_x, def_y, n % 800, n / 800); end
      checks++; if (def_hs !== ~hsd || def_vs !== ~vsd) begin errors++;
        $display("FAIL def_sync n=%0d got %b,%b exp %b,%b", n, def_hs, def_vs, ~hsd, ~vsd); end
      checks++; if (def_de !== de) begin errors++;
        $display("FAIL def_blank n=%0d got %b exp %b", n, def_de, de); end
      checks++; if (def_eol !== ((n % 800) == 799) || def_sof !== 1'b0) begin errors++;
        $display("FAIL def_strobes n=%0d got eol=%b sof=%b exp %b,0", n, def_eol, def_sof, (n % 800) == 799); end
      checks++; if (pol_hs !== hsd || pol_vs !== vsd) begin errors++;
        $display("FAIL pol_sync n=%0d got %b,%b exp %b,%b", n, pol_hs, pol_vs, hsd, vsd); end
      checks++; if (d4_de !== de4 || d4_hs !== ~hsd4) begin errors++;
        $display("FAIL d4_pipe n=%0d got de=%b hs=%b exp %b,%b", n, d4_de, d4_hs, de4, ~hsd4); end
      if (def_hs === 1'b0 && first_hs < 0) first_hs = n;
      if (def_hs === 1'b0) hs_run++;
      else if (hs_run > 0 && run_done == 0) begin
        run_done = 1;
        checks++; if (hs_run != 96) begin errors++;
          $display("FAIL hs_width got %0d exp 96", hs_run); end
      end
      if (d4_de === 1'b1 && prev_de4 === 1'b0 && de4_rise < 0) de4_rise = n;
      if (d4_de === 1'b0 && prev_de4 === 1'b1 && de4_fall < 0) de4_fall = n;
      prev_de4 = d4_de;
      if (def_eol === 1'b1) begin if (eol0 < 0) eol0 = n; else if (eol1 < 0) eol1 = n; end
    end
    checks++; if (first_hs != 657) begin errors++;
      $display("FAIL hs_first_low got %0d exp 657", first_hs); end
    checks++; if (run_done == 0) begin errors++;
      $display("FAIL hs_width got no completed pulse exp 96"); end
    checks++; if (de4_rise != 4 || de4_fall != 644) begin errors++;
      $display("FAIL d4_de_edges got %0d,%0d exp 4,644", de4_rise, de4_fall); end
    checks++; if (eol1 - eol0 != 800 || eol0 != 799) begin errors++;
      $display("FAIL eol_interval got %0d,%0d exp 799,1599", eol0, eol1); end
    checks++; if (def_fc !== 16'd0) begin errors++;
      $display("FAIL def_frame_cnt got %0d exp 0", def_fc); end
  endtask

  task automatic test_small_frames();
    bit         hsd, vsd, de;
    int         n, vs_run = 0, run_done = 0, sof_prev = 0, sof_int = 0;
    logic [1:0] efc;
    @(negedge clk); rst_s = 1'b0;
    for (int k = 0; k < 4 * 84 + 10; k++) begin
      @(posedge clk); #1;
      n = n_s;
      exp_dec(n, 1, 12, 7, 9, 2, 5, 1, 8, 4, hsd, vsd, de);
`ifdef VTG_FRAME_CNT_EN
      efc = 2'((n / 84) % 4);
`else
      efc = 2'd0;
`endif
      checks++; if (sm_x !== 10'(n % 12) || sm_y !== 10'((n / 12) % 7)) begin errors++;
        $display("FAIL sm_xy n=%0d got %0d,%0d exp %0d,%0d", n, sm_x, sm_y, n % 12, (n / 12) % 7); end
      checks++; if (sm_hs !== ~hsd || sm_vs !== ~vsd || sm_de !== de) begin errors++;
        $display("FAIL sm_pipe n=%0d got %b%b%b exp %b%b%b", n, sm_hs, sm_vs, sm_de, ~hsd, ~vsd, de); end
      checks++; if (sm_sof !== ((n % 84) == 0) || sm_eol !== ((n % 12) == 11)) begin errors++;
        $display("FAIL sm_strobes n=%0d got sof=%b eol=%b", n, sm_sof, sm_eol); end
      checks++; if (sm_fc !== efc) begin errors++;
        $display("FAIL sm_frame_cnt n=%0d got %0d exp %0d", n, sm_fc, efc); end
      if (sm_vs === 1'b0) vs_run++;
      else if (vs_run > 0 && run_done == 0) begin
        run_done = 1;
        checks++; if (vs_run != 12) begin errors++;
          $display("FAIL sm_vs_width got %0d exp 12", vs_run); end
      end
      if (sm_sof === 1'b1) begin
        if (sof_prev > 0 && sof_int == 0) sof_int = n - sof_prev;
        sof_prev = n;
      end
    end
    checks++; if (sof_int != 84) begin errors++;
      $display("FAIL sm_sof_interval got %0d exp 84", sof_int); end
  endtask

  task automatic test_reset_midframe();
    int found = 0, n, sof1 = -1, sof2 = -1;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(posedge clk); #1;
      if (sm_x === 10'd5 && sm_y === 10'd3) found = 1;
    end
    checks++; if (found == 0) begin errors++;
      $display("FAIL midframe_wait got timeout exp position 5,3"); end
    #2; rst_s = 1'b1; #1;
    checks++; if (sm_x !== 10'd0 || sm_y !== 10'd0 || sm_sof !== 1'b1) begin errors++;
      $display("FAIL midframe_async_xy got %0d,%0d sof=%b exp 0,0,1", sm_x, sm_y, sm_sof); end
    checks++; if (sm_hs !== 1'b1 || sm_vs !== 1'b1 || sm_de !== 1'b0) begin errors++;
      $display("FAIL midframe_async_pipe got %b%b%b exp 110", sm_hs, sm_vs, sm_de); end
    @(negedge clk); @(negedge clk); rst_s = 1'b0;
    for (int k = 0; k < 2 * 84 + 5; k++) begin
      @(posedge clk); #1;
      n = n_s;
      if (sm_sof === 1'b1) begin if (sof1 < 0) sof1 = n; else if (sof2 < 0) sof2 = n; end
      if (k == 6) begin
        checks++; if (sm_x !== 10'd7 || sm_y !== 10'd0) begin errors++;
          $display("FAIL midframe_restart got %0d,%0d exp 7,0", sm_x, sm_y); end
      end
    end
    checks++; if (sof1 != 84 || sof2 != 168) begin errors++;
      $display("FAIL midframe_sof got %0d,%0d exp 84,168", sof1, sof2); end
  endtask

  initial begin
    test_reset();
    test_default_lines();
    test_small_frames();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator, successor to the fixed 640x480 `vga_controller`. Counts pixel and line positions for any resolution and porch set, and emits `drawX`/`drawY` as the lead position for the colour pipeline. Sync and blank outputs are delayed by a configurable number of cycles so they arrive in step with a multi-cycle graphics/sprite pipeline. It also provides frame/line strobes and an optional frame counter. It sits between `clk_wiz_0` (25 MHz) and `hdmi_tx_0` in the HDMI top level.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HS_POL`, 1'b0: active level of `hs`.
- `VS_POL`, 1'b0: active level of `vs`.
- `XY_W`, 10: width of `drawX`/`drawY`. Must hold `H_TOTAL-1` and `V_TOTAL-1`.
- `DELAY`, 1: register stages on `hs`/`vs`/`active_nblank`. Legal range is 1..8.
- `FRAME_W`, 16: width of `frame_cnt`.

Ports:
- `pixel_clk`, in, 1: pixel clock. This is the only clock.
- `reset`, in, 1: reset, asynchronous and active-high.
- `drawX`, out, `XY_W`: current pixel column (the horizontal counter).
- `drawY`, out, `XY_W`: current line (the vertical counter).
- `hs`, out, 1: horizontal sync, delayed by `DELAY` cycles.
- `vs`, out, 1: vertical sync, delayed by `DELAY` cycles.
- `active_nblank`, out, 1: high inside the visible area, delayed by `DELAY` cycles.
- `sof`, out, 1: one-cycle pulse while `drawX==0 && drawY==0`. Not delayed.
- `eol`, out, 1: one-cycle pulse while `drawX==H_TOTAL-1`. Not delayed.
- `frame_cnt`, out, `FRAME_W`: number of completed frames, wrapping.

## Operation
- Derived totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` and `V_TOTAL` likewise.
- Horizontal counter `hc`:
  - Increments every clock.
  - At `H_TOTAL-1` it wraps to 0 and advances the vertical counter `vc`.
  - `vc` wraps to 0 after `V_TOTAL-1`.
  - Simultaneous wrap at (`H_TOTAL-1`, `V_TOTAL-1`) goes to (0,0) in one edge and increments `frame_cnt`.
- `drawX=hc` and `drawY=vc`. Both are registered outputs, not decoded.
- Decoded terms, all computed from the current (`hc`,`vc`):
  - `hs_d = (hc >= H_ACTIVE+H_FP) && (hc < H_ACTIVE+H_FP+H_SYNC)`.
  - `vs_d`: same form on `vc` with the vertical parameters.
  - `de_d = (hc < H_ACTIVE) && (vc < V_ACTIVE)`.
- Sync polarity: `hs` = `hs_d` XNOR'd with `HS_POL`, so `hs` equals `HS_POL` while `hs_d` is true. `vs` uses `VS_POL` the same way.
- The decoded terms pass through a `DELAY`-deep shift register.
- `sof` and `eol` are combinational from the counters, so they are aligned with `drawX`/`drawY`.
- `frame_cnt` wraps from `2^FRAME_W-1` to 0.

## Timing
- Reset values (asserted, or asynchronously on assertion):
  - `hc`=0, `vc`=0, `drawX`=0, `drawY`=0.
  - Every delay stage is cleared to inactive: `hs`=`~HS_POL`, `vs`=`~VS_POL`, `active_nblank`=0.
  - `frame_cnt`=0.
  - `sof`=1, because the counters are at (0,0).
- After release: the first rising edge moves `hc` from 0 to 1.
- Latency: `hs`/`vs`/`active_nblank` at edge n reflect (`hc`,`vc`) at edge n-`DELAY`.
- Start-up: the first `DELAY` cycles after release show inactive syncs and blank. This is not a decode of position 0.
- Reset mid-frame: counters and pipeline clear immediately. There is no partial-frame flush. The frame restarts at (0,0) on release.
- `DELAY` outside 1..8, or `XY_W` too narrow: elaboration error via `$error` in a generate check.

## Configuration
- `VTG_FRAME_CNT_EN` defined: the `frame_cnt` register is built and increments as above.
- Not defined: `frame_cnt` is tied to 0 and no counter logic is synthesised. All other behaviour is unchanged.

## Test plan
- Defaults, `DELAY`=1, release reset -> `hs` first low on the edge where `hc` has been 656 for one cycle (edge 657). `hs` stays low for 96 cycles, then returns high.
- Defaults -> `eol` pulses every 800 cycles. `sof` pulses every 420000 cycles. `vs` is low for exactly 1600 consecutive cycles per frame.
- `DELAY`=4 -> `active_nblank` rises 4 cycles after `drawX` reaches 0 on line 0, and falls 4 cycles after `drawX`=640.
- Small config: H 8/1/2/1, V 4/1/1/1, `VTG_FRAME_CNT_EN` on, `FRAME_W`=2 -> `frame_cnt` sequence 0,1,2,3,0 at 84-cycle intervals.
- Assert reset at `hc`=300, `vc`=200 -> on that cycle, asynchronously, `drawX`=`drawY`=0, `hs`/`vs` inactive, `active_nblank`=0. After release, the next `sof` follows 420000 cycles after the first.
- `HS_POL`=1, `VS_POL`=1 -> sync pulses are high for the same windows, and both are low during reset.
